// File: rtl/awg_serial_loader_pkg.sv
// Shared definitions for the AWG serial loader: FSM state encodings and a
// counter-width helper that never returns zero.
package awg_serial_loader_pkg;

  typedef logic [1:0] state_t;

  localparam state_t S_IDLE  = 2'd0;
  localparam state_t S_SHIFT = 2'd1;
  localparam state_t S_LOAD  = 2'd2;

  // Width needed to count 0..n-1; at least 1 bit so n=1 still yields a legal vector.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/awg_serial_loader_tick.sv
// Half-period divider for the serial clock. Counts while enabled, flips phase
// every HALF_PERIOD cycles, and returns to phase 0 / count 0 whenever disabled.
module awg_ser_tick
  import awg_serial_loader_pkg::*;
#(
  parameter int HALF_PERIOD = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic half_tick,
  output logic phase,
  output logic phase_nxt
);

  localparam int CW = cnt_w(HALF_PERIOD);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          phase_q, phase_d;

  assign half_tick = en && (cnt_q == CW'(HALF_PERIOD - 1));

  always_comb begin
    cnt_d   = '0;
    phase_d = 1'b0;
    if (en) begin
      if (half_tick) begin
        cnt_d   = '0;
        phase_d = ~phase_q;
      end else begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase     = phase_q;
  // Next-cycle phase lets the top register ser_clk without a cycle of lag.
  assign phase_nxt = phase_d;

endmodule

// File: rtl/awg_serial_loader.sv
// Serial transmitter for the AWG sequencer index: rotated-order shift-out with
// generated ser_clk, then a ser_load strobe. Define AWG_SER_QUEUE_EN for a
// one-entry holding register that chains frames back to back.
module awg_serial_loader
  import awg_serial_loader_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int START_IDX   = 1,
  parameter int HALF_PERIOD = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              busy,
  output logic              done,
  output logic              ser_clk,
  output logic              ser_data,
  output logic              ser_load
);

  localparam int BW = cnt_w(DATA_W);
  localparam int IW = BW + 1;

  state_t            state_q, state_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              sclk_q, sclk_d;
  logic              sdat_q, sdat_d;
  logic              sload_q, sload_d;
  logic [IW-1:0]     idx;

  logic tick_en, half_tick, phase, phase_nxt;
  logic accept, bit_end, load_end, last_bit;

`ifdef AWG_SER_QUEUE_EN
  logic [DATA_W-1:0] hold_q, hold_d;
  logic              held_q, held_d;
`endif

  assign tick_en  = (state_q != S_IDLE);
  assign accept   = start && ready_q;
  assign bit_end  = (state_q == S_SHIFT) && half_tick && phase;
  assign load_end = (state_q == S_LOAD) && half_tick && phase;
  assign last_bit = (bit_q == BW'(DATA_W - 1));

  awg_ser_tick #(.HALF_PERIOD(HALF_PERIOD)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (tick_en),
    .half_tick (half_tick),
    .phase     (phase),
    .phase_nxt (phase_nxt)
  );

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    word_d  = word_q;
    done_d  = 1'b0;
`ifdef AWG_SER_QUEUE_EN
    hold_d  = hold_q;
    held_d  = held_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_SHIFT;
          bit_d   = '0;
          word_d  = data;
        end
      end
      S_SHIFT: begin
        if (bit_end) begin
          if (last_bit) state_d = S_LOAD;
          else          bit_d   = bit_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (load_end) begin
          done_d  = 1'b1;
          bit_d   = '0;
          state_d = S_IDLE;
`ifdef AWG_SER_QUEUE_EN
          // A held word, or one arriving right now, skips the idle cycle.
          if (held_q) begin
            state_d = S_SHIFT;
            word_d  = hold_q;
            held_d  = 1'b0;
          end else if (accept) begin
            state_d = S_SHIFT;
            word_d  = data;
          end
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef AWG_SER_QUEUE_EN
    if (accept && (state_q != S_IDLE) && !load_end) begin
      hold_d = data;
      held_d = 1'b1;
    end
`endif

    // Rotated bit order: wrap START_IDX+k back into 0..DATA_W-1.
    idx = IW'(bit_d) + IW'(START_IDX);
    if (idx >= IW'(DATA_W)) idx = idx - IW'(DATA_W);

    sdat_d  = (state_d == S_SHIFT) && word_d[idx[BW-1:0]];
    sclk_d  = (state_d == S_SHIFT) && phase_nxt;
    sload_d = (state_d == S_LOAD);
    busy_d  = (state_d != S_IDLE);
`ifdef AWG_SER_QUEUE_EN
    ready_d = !held_d;
`else
    ready_d = (state_d == S_IDLE);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      bit_q   <= '0;
      word_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk_q  <= 1'b0;
      sdat_q  <= 1'b0;
      sload_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      word_q  <= word_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      sclk_q  <= sclk_d;
      sdat_q  <= sdat_d;
      sload_q <= sload_d;
    end
  end

`ifdef AWG_SER_QUEUE_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      held_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      held_q <= held_d;
    end
  end
`endif

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ser_clk  = sclk_q;
  assign ser_data = sdat_q;
  assign ser_load = sload_q;

endmodule

// File: tb/tb_awg_serial_loader.sv
// Bench for awg_serial_loader: three configurations checked cycle by cycle
// against a frame-timeline model built from bit index, bit time and load time.
module tb_awg_serial_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  start = 3'b000;
  logic [15:0] d0 = '0;
  logic [7:0]  d8 = '0;
  logic [15:0] d2 = '0;
  wire  [2:0]  ready, busy, done, sclk, sdat, sload;

  int checks = 0;
  int errors = 0;
  int W[3] = '{16, 8, 16};
  int S[3] = '{1, 0, 1};
  int H[3] = '{2, 2, 1};

  awg_serial_loader u0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .data(d0), .ready(ready[0]), .busy(busy[0]),
    .done(done[0]), .ser_clk(sclk[0]), .ser_data(sdat[0]), .ser_load(sload[0]));

  awg_serial_loader #(.DATA_W(8), .START_IDX(0), .HALF_PERIOD(2)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .data(d8), .ready(ready[1]), .busy(busy[1]),
    .done(done[1]), .ser_clk(sclk[1]), .ser_data(sdat[1]), .ser_load(sload[1]));

  awg_serial_loader #(.DATA_W(16), .START_IDX(1), .HALF_PERIOD(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .data(d2), .ready(ready[2]), .busy(busy[2]),
    .done(done[2]), .ser_clk(sclk[2]), .ser_data(sdat[2]), .ser_load(sload[2]));

  task automatic set_in(input int u, input logic s, input logic [15:0] d);
    start[u] = s;
    case (u)
      0: d0 = d;
      1: d8 = d[7:0];
      default: d2 = d;
    endcase
  endtask

  // Expected {busy, ser_clk, ser_data, ser_load, done} k cycles after acceptance.
  function automatic logic [4:0] exp_vec(input int u, input logic [15:0] d, input int k);
    int bl;
    int b;
    bl = 2 * H[u];
    if (k < W[u] * bl) begin
      b = (S[u] + k / bl) % W[u];
      return {1'b1, logic'((k % bl) >= H[u]), d[b], 1'b0, 1'b0};
    end
    if (k < (W[u] + 1) * bl) return 5'b10010;
    return 5'b00001;
  endfunction

  function automatic logic [4:0] obs(input int u);
    return {busy[u], sclk[u], sdat[u], sload[u], done[u]};
  endfunction

  task automatic launch(input int u, input logic [15:0] d);
    @(negedge clk);
    checks++;
    if (ready[u] !== 1'b1) begin
      errors++;
      $display("FAIL launch_ready u%0d got %b want 1", u, ready[u]);
    end
    set_in(u, 1'b1, d);
    @(posedge clk);
    #1 set_in(u, 1'b0, 16'($urandom));
  endtask

  task automatic check_frame(input int u, input logic [15:0] d, input int poke, input bit chain,
                             input logic [15:0] nd);
    int L;
    logic [4:0] e;
    L = (W[u] + 1) * 2 * H[u];
    for (int k = 0; k <= L; k++) begin
      @(negedge clk);
      e = exp_vec(u, d, k);
      checks++;
      if (obs(u) !== e) begin
        errors++;
        $display("FAIL frame u%0d k%0d data %h got %b want %b", u, k, d, obs(u), e);
      end
`ifndef AWG_SER_QUEUE_EN
      checks++;
      if (ready[u] !== ~e[4]) begin
        errors++;
        $display("FAIL ready u%0d k%0d got %b want %b", u, k, ready[u], ~e[4]);
      end
`endif
      if (poke > 0 && k == 3) set_in(u, 1'b1, 16'($urandom));
      if (poke > 0 && k == 3 + poke) set_in(u, 1'b0, 16'($urandom));
      if (chain && k == L) set_in(u, 1'b1, nd);
    end
    if (chain) begin
      @(posedge clk);
      #1 set_in(u, 1'b0, 16'($urandom));
    end
  endtask

  task automatic expect_quiet(input int u, input int n, input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy[u] !== 1'b0 || sload[u] !== 1'b0 || done[u] !== 1'b0 || sclk[u] !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL quiet_%s u%0d got %0d active cycles want 0", tag, u, bad);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 3; u++) begin
      checks++;
      if (obs(u) !== 5'b0 || ready[u] !== 1'b1) begin
        errors++;
        $display("FAIL reset u%0d got %b/%b want 00000/1", u, obs(u), ready[u]);
      end
    end
    rst_n = 1'b1;
    expect_quiet(0, 3, "after_reset");
  endtask

  task automatic test_pattern;
    logic [15:0] d;
    launch(0, 16'h8001);
    check_frame(0, 16'h8001, 0, 1'b0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      d = 16'($urandom);
      launch(0, d);
      check_frame(0, d, 0, 1'b0, 16'h0);
    end
  endtask

  task automatic test_order8;
    logic [15:0] d;
    launch(1, 16'h00A5);
    check_frame(1, 16'h00A5, 0, 1'b0, 16'h0);
    for (int i = 0; i < 2; i++) begin
      d = {8'h00, 8'($urandom)};
      launch(1, d);
      check_frame(1, d, 0, 1'b0, 16'h0);
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] a, b, c;
    a = 16'($urandom);
    b = 16'($urandom);
    c = 16'($urandom);
    launch(2, a);
    check_frame(2, a, 0, 1'b1, b);
    check_frame(2, b, 0, 1'b1, c);
    check_frame(2, c, 0, 1'b0, 16'h0);
    expect_quiet(2, 4, "b2b_tail");
  endtask

  task automatic test_ignore_busy;
    logic [15:0] d;
    d = 16'($urandom);
    launch(0, d);
    check_frame(0, d, 20, 1'b0, 16'h0);
    expect_quiet(0, 10, "ignored_start");
  endtask

  task automatic test_reset_mid;
    logic [15:0] d;
    d = 16'($urandom) | 16'h0100;
    launch(0, d);
    for (int k = 0; k <= 7 * 4 + 1; k++) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (obs(0) !== 5'b0 || ready[0] !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid got %b/%b want 00000/1", obs(0), ready[0]);
    end
    expect_quiet(0, 80, "post_abort");
    d = 16'($urandom);
    launch(0, d);
    check_frame(0, d, 0, 1'b0, 16'h0);
  endtask

`ifdef AWG_SER_QUEUE_EN
  task automatic test_queue;
    int L;
    logic [4:0] e;
    logic       er;
    L = (W[0] + 1) * 2 * H[0];
    launch(0, 16'h0001);
    for (int m = 0; m <= 2 * L; m++) begin
      @(negedge clk);
      if (m < L) e = exp_vec(0, 16'h0001, m);
      else       e = exp_vec(0, 16'hFFFF, m - L) | {4'b0, logic'(m == L)};
      er = !(m >= 6 && m < L);
      checks++;
      if (obs(0) !== e || ready[0] !== er) begin
        errors++;
        $display("FAIL queue m%0d got %b/%b want %b/%b", m, obs(0), ready[0], e, er);
      end
      if (m == 5) set_in(0, 1'b1, 16'hFFFF);
      if (m == 6) set_in(0, 1'b0, 16'h0);
    end
    expect_quiet(0, 4, "queue_tail");
  endtask
`endif

  initial begin
    test_reset;
    test_pattern;
    test_order8;
    test_back_to_back;
`ifdef AWG_SER_QUEUE_EN
    test_queue;
`else
    test_ignore_busy;
`endif
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
